// File: rtl/mod_up_counter_pkg.sv
// Shared types and constants for the modulo up-counter.
package mod_up_counter_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } mod_up_state_t;

   localparam int unsigned COUNT_RST_VAL = 0;

endpackage

// File: rtl/mod_up_counter.sv
// Programmable modulo up-counter: free-run wrap or one-shot halt at a run-time limit.
// Define MOD_UP_COUNTER_LOAD_EN to enable the synchronous load port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | counting on enable; wraps or halts on reaching limit
// ST_HALT | one-shot finished at limit; only clear/load/rst leave here
module mod_up_counter
   import mod_up_counter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         clear,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic [N-1:0] limit,
   input  logic         oneshot,
   output logic [N-1:0] count,
   output logic         tc,
   output logic         wrap,
   output logic         done
);

   mod_up_state_t state_q, state_d;
   logic [N-1:0]  count_q, count_d;
   logic          wrap_q, wrap_d;
   logic          done_q, done_d;
   logic          load_hit;

`ifdef MOD_UP_COUNTER_LOAD_EN
   assign load_hit = load;
`else
   logic unused_load;
   assign unused_load = ^{load, load_val};
   assign load_hit    = 1'b0;
`endif

   assign tc = (count_q == limit);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wrap_d  = 1'b0;
      if (clear) begin
         state_d = ST_RUN;
         count_d = N'(COUNT_RST_VAL);
      end else if (load_hit) begin
         state_d = ST_RUN;
`ifdef MOD_UP_COUNTER_LOAD_EN
         count_d = load_val;
`endif
      end else if (state_q == ST_RUN && enable) begin
         if (!tc) begin
            // a natural all-ones rollover above limit is silent
            count_d = count_q + 1'b1;
         end else if (oneshot) begin
            state_d = ST_HALT;
         end else begin
            count_d = N'(COUNT_RST_VAL);
            wrap_d  = 1'b1;
         end
      end
      done_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         count_q <= N'(COUNT_RST_VAL);
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;
   assign done  = done_q;

endmodule
